vc_input_unit: RTL

// - Complete router input unit: VC_NUM virtual channels, each with its own flit FIFO and IDLE/VA/SA control FSM.
// - Steers each incoming flit to a FIFO by its vc_id.
// - Presents per-VC VC-allocation and switch-allocation requests, and muxes the granted VC's flit onto one output.
// - Returns one credit per departed flit to the upstream router; this replaces on/off backpressure.

---
 rtl/noc_params.sv | 29 ++
 rtl/vc_fifo.sv | 66 ++++++
 rtl/vc_input_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/noc_params.sv
// Shared NoC types and sizes used by the router input unit.
package noc_params;

    localparam int unsigned VC_NUM  = 2;
    localparam int unsigned VC_SIZE = $clog2(VC_NUM);
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned PORT_W  = 3;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

    typedef enum logic [PORT_W-1:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

    typedef enum logic [1:0] {IDLE, VA, SA} vc_state_t;

    typedef struct packed {
        flit_label_t         flit_label;
        logic [VC_SIZE-1:0]  vc_id;
        logic [DATA_W-1:0]   data;
    } flit_t;

    function automatic logic is_head(input flit_label_t l);
        return (l == HEAD) || (l == HEADTAIL);
    endfunction

    function automatic logic is_tail(input flit_label_t l);
        return (l == TAIL) || (l == HEADTAIL);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-VC circular flit buffer: registered write, combinational head read.
module vc_fifo
    import noc_params::*;
#(
    parameter int unsigned BUFFER_SIZE = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  flush_i,
    input  logic  push_i,
    input  logic  pop_i,
    input  flit_t data_i,
    output flit_t data_o,
    output logic  is_empty_o,
    output logic  is_full_o
);

    localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;

    flit_t              mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign is_empty_o = (count_q == '0);
    assign is_full_o  = (count_q == CNT_W'(BUFFER_SIZE));
    assign data_o     = mem_q[rd_ptr_q];

    // A push into a full buffer is only legal when a pop frees the slot in the same cycle.
    assign do_pop  = pop_i && !is_empty_o;
    assign do_push = push_i && (!is_full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/vc_input_unit.sv
// Router input unit: per-VC buffering and IDLE/VA/SA control, shared read mux and credit return.
module vc_input_unit
    import noc_params::*;
#(
    parameter int unsigned BUFFER_SIZE = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  flit_t                           data_i,
    input  logic                            valid_i,
    input  port_t                           out_port_i,
    input  logic [VC_NUM-1:0]               vc_valid_i,
    input  logic [VC_NUM-1:0][VC_SIZE-1:0]  vc_new_i,
    input  logic [VC_NUM-1:0]               read_i,
    output flit_t                           data_o,
    output logic [VC_NUM-1:0][PORT_W-1:0]   out_port_o,
    output logic [VC_NUM-1:0][VC_SIZE-1:0]  downstream_vc_o,
    output logic [VC_NUM-1:0]               vc_request_o,
    output logic [VC_NUM-1:0]               switch_request_o,
    output logic [VC_NUM-1:0]               vc_allocatable_o,
    output logic                            credit_valid_o,
    output logic [VC_SIZE-1:0]              credit_vc_o,
    output logic [VC_NUM-1:0]               is_empty_o,
    output logic [VC_NUM-1:0]               is_full_o,
    output logic [VC_NUM-1:0]               error_o
);

    vc_state_t                       state_q [VC_NUM];
    vc_state_t                       state_d [VC_NUM];
    logic [VC_NUM-1:0]               end_packet_q, end_packet_d;
    logic [VC_NUM-1:0][PORT_W-1:0]   out_port_q, out_port_d;
    logic [VC_NUM-1:0][VC_SIZE-1:0]  dvc_q, dvc_d;
    logic [VC_NUM-1:0]               error_q, error_d;
    logic [VC_NUM-1:0]               alloc_q, alloc_d;
    logic                            credit_valid_q, credit_valid_d;
    logic [VC_SIZE-1:0]              credit_vc_q, credit_vc_d;

    flit_t                           fifo_head [VC_NUM];
    logic [VC_NUM-1:0]               fifo_empty, fifo_full;
    logic [VC_NUM-1:0]               push, flush, wr_hit, pop_ok, rd_err;
    logic                            multi_read;

    assign multi_read = (read_i & (read_i - VC_NUM'(1))) != '0;

    for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
        assign wr_hit[g] = valid_i && (data_i.vc_id == VC_SIZE'(g));
        assign pop_ok[g] = read_i[g] && !multi_read && (state_q[g] == SA) && !fifo_empty[g];
        assign rd_err[g] = read_i[g] && !pop_ok[g];

        assign vc_request_o[g]     = (state_q[g] == VA);
        assign switch_request_o[g] = (state_q[g] == SA) && !fifo_empty[g];

        vc_fifo #(
            .BUFFER_SIZE (BUFFER_SIZE)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .flush_i    (flush[g]),
            .push_i     (push[g]),
            .pop_i      (pop_ok[g]),
            .data_i     (data_i),
            .data_o     (fifo_head[g]),
            .is_empty_o (fifo_empty[g]),
            .is_full_o  (fifo_full[g])
        );
    end

    // Per-VC control: write acceptance, allocation handshakes and protocol checks.
    always_comb begin
        end_packet_d = end_packet_q;
        out_port_d   = out_port_q;
        dvc_d        = dvc_q;
        error_d      = rd_err;
        alloc_d      = '0;
        push         = '0;
        flush        = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            state_d[v] = state_q[v];
            case (state_q[v])
                IDLE: begin
                    if (wr_hit[v]) begin
                        if (is_head(data_i.flit_label) && fifo_empty[v]) begin
                            push[v]         = 1'b1;
                            state_d[v]      = VA;
                            out_port_d[v]   = out_port_i;
                            end_packet_d[v] = is_tail(data_i.flit_label);
                        end else begin
                            error_d[v] = 1'b1;
                        end
                    end
                    if (vc_valid_i[v]) error_d[v] = 1'b1;
                end
                VA, SA: begin
                    if (wr_hit[v]) begin
                        if (!is_head(data_i.flit_label) && !end_packet_q[v]
                            && (!fifo_full[v] || pop_ok[v])) begin
                            push[v] = 1'b1;
                            if (is_tail(data_i.flit_label)) end_packet_d[v] = 1'b1;
                        end else begin
                            error_d[v] = 1'b1;
                        end
                    end
                    if (state_q[v] == VA) begin
                        if (vc_valid_i[v]) begin
                            dvc_d[v]   = vc_new_i[v];
                            state_d[v] = SA;
                        end
                    end else begin
                        if (vc_valid_i[v]) error_d[v] = 1'b1;
                        if (pop_ok[v] && is_tail(fifo_head[v].flit_label)) begin
                            state_d[v]      = IDLE;
                            end_packet_d[v] = 1'b0;
                            alloc_d[v]      = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[v]      = IDLE;
                    flush[v]        = 1'b1;
                    end_packet_d[v] = 1'b0;
                    error_d[v]      = 1'b1;
                    alloc_d[v]      = 1'b1;
                end
            endcase
        end
    end

    // Shared credit return: at most one pop per cycle since reads must be one-hot.
    always_comb begin
        credit_valid_d = 1'b0;
        credit_vc_d    = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            if (pop_ok[v]) begin
                credit_valid_d = 1'b1;
                credit_vc_d    = VC_SIZE'(v);
            end
        end
    end

    // Output mux relabels the flit with its downstream VC.
    always_comb begin
        data_o = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            if (read_i[v] && !multi_read) begin
                data_o       = fifo_head[v];
                data_o.vc_id = dvc_q[v];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                state_q[v]    <= IDLE;
                out_port_q[v] <= PORT_W'(LOCAL);
            end
            end_packet_q   <= '0;
            dvc_q          <= '0;
            error_q        <= '0;
            alloc_q        <= '0;
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
        end else begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                state_q[v] <= state_d[v];
            end
            end_packet_q   <= end_packet_d;
            out_port_q     <= out_port_d;
            dvc_q          <= dvc_d;
            error_q        <= error_d;
            alloc_q        <= alloc_d;
            credit_valid_q <= credit_valid_d;
            credit_vc_q    <= credit_vc_d;
        end
    end

    assign out_port_o       = out_port_q;
    assign downstream_vc_o  = dvc_q;
    assign vc_allocatable_o = alloc_q;
    assign credit_valid_o   = credit_valid_q;
    assign credit_vc_o      = credit_vc_q;
    assign is_empty_o       = fifo_empty;
    assign is_full_o        = fifo_full;
    assign error_o          = error_q;

endmodule
